// File: rtl/dp_ram_avalon_loader.sv
// Block loader for the dpRam Avalon-MM slave port.
// Takes a {dir, base, len} command and streams words into the RAM (write)
// or out of it (read). It programs the slave's host address and
// write-enable registers and then moves data through the auto-incrementing
// data window.
module dp_ram_avalon_loader #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 12,
  parameter int READ_GAP = 0
) (
  input  logic              avalon_clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2:0]        avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              done,
  output logic              busy
);

  // The remaining-word counter must hold the full 2**ADDR_W block size
  // even when LEN_W is no wider than ADDR_W.
  localparam int CNT_W = (LEN_W > ADDR_W) ? LEN_W : ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;
  localparam int GAP_W = (READ_GAP > 1) ? $clog2(READ_GAP) : 1;

  // dpRam register map
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_ADDR = 3'd1;
  localparam logic [2:0] REG_WE   = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_WE,
    S_W_DATA,
    S_W_WEOFF,
    S_R_WE,
    S_R_ADDR,
    S_R_ISSUE,
    S_R_CAP,
    S_R_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;

  logic [CNT_W-1:0]   len_ext;
  logic [CNT_W-1:0]   len_clamped;

  assign len_ext     = CNT_W'(cmd_len);
  assign len_clamped = (len_ext > MAX_WORDS) ? MAX_WORDS : len_ext;

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign busy    = ~cmd_ready;

  // State register, command latch, counters and the one-word output buffer.
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      remain_q  <= '0;
      gap_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      remain_q  <= remain_d;
      gap_q     <= gap_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Next-state logic and bus/stream strobes; every output defaults to idle.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    remain_d      = remain_q;
    gap_d         = gap_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q & ~m_ready;
    cmd_ready     = 1'b0;
    s_ready       = 1'b0;
    done          = 1'b0;
    avm_address   = 3'd0;
    avm_write     = 1'b0;
    avm_writedata = 32'd0;
    avm_read      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end

      S_W_ADDR: begin
        avm_write     = 1'b1;
        avm_address   = REG_ADDR;
        avm_writedata = 32'(base_q);
        state_d       = S_W_WE;
      end

      S_W_WE: begin
        avm_write     = 1'b1;
        avm_address   = REG_WE;
        avm_writedata = 32'd1;
        state_d       = S_W_DATA;
      end

      S_W_DATA: begin
        s_ready = 1'b1;
        if (s_valid) begin
          avm_write     = 1'b1;
          avm_address   = REG_DATA;
          avm_writedata = 32'(s_data);
          remain_d      = remain_q - CNT_W'(1);
          // Write-enable must drop in the very next cycle, otherwise the
          // slave keeps writing past the block.
          if (remain_q == CNT_W'(1)) begin
            state_d = S_W_WEOFF;
          end
        end
      end

      S_W_WEOFF: begin
        avm_write     = 1'b1;
        avm_address   = REG_WE;
        avm_writedata = 32'd0;
        state_d       = S_DONE;
      end

      // Write-enable goes off before the address load so a stale enable
      // cannot overwrite the base word.
      S_R_WE: begin
        avm_write     = 1'b1;
        avm_address   = REG_WE;
        avm_writedata = 32'd0;
        state_d       = S_R_ADDR;
      end

      S_R_ADDR: begin
        avm_write     = 1'b1;
        avm_address   = REG_ADDR;
        avm_writedata = 32'(base_q);
        state_d       = S_R_ISSUE;
      end

      S_R_ISSUE: begin
        // Only read when the captured word has somewhere to go.
        if (!m_valid_q || m_ready) begin
          avm_read    = 1'b1;
          avm_address = REG_DATA;
          state_d     = S_R_CAP;
        end
      end

      S_R_CAP: begin
        m_data_d  = DATA_W'(avm_readdata);
        m_valid_d = 1'b1;
        remain_d  = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else if (READ_GAP > 0) begin
          gap_d   = GAP_W'(READ_GAP - 1);
          state_d = S_R_GAP;
        end else begin
          state_d = S_R_ISSUE;
        end
      end

      S_R_GAP: begin
        if (gap_q == '0) begin
          state_d = S_R_ISSUE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_DONE: begin
        // Hold here until the last read word has been taken.
        if (!m_valid_q) begin
          done      = 1'b1;
          cmd_ready = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cmd_ready && cmd_valid) begin
      base_d   = cmd_base;
      remain_d = len_clamped;
      if (len_clamped == '0) begin
        state_d = S_DONE;
      end else if (cmd_dir) begin
        state_d = S_R_WE;
      end else begin
        state_d = S_W_ADDR;
      end
    end
  end

endmodule

// File: tb/tb_dp_ram_avalon_loader.sv
`timescale 1ns/1ps
// Bench for dp_ram_avalon_loader: a behavioural dpRam slave, a reference
// memory image, a command table, hand-written corner sequences and
// randomized commands.
module tb_dp_ram_avalon_loader;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [10:0] cmd_base;
  logic [11:0] cmd_len;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready;
  logic [2:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata, avm_readdata;
  logic        done, busy;

  always #5 clk = ~clk;

  dp_ram_avalon_loader dut (
    .avalon_clock (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .avm_address  (avm_address),
    .avm_write    (avm_write),
    .avm_writedata(avm_writedata),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .done         (done),
    .busy         (busy)
  );

  typedef struct {
    int          cyc;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    bit          dir;
    logic [10:0] base;
    logic [11:0] len;
    int          pol;
    bit          inject;
    int          exp_words;
    int          exp_bus;
  } vec_t;

  ev_t         ev_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem[DEPTH];
  logic [31:0] ram[DEPTH];
  logic [10:0] haddr = 11'd0;
  bit          hwe = 1'b0;
  bit          ram_init = 1'b0;
  bit          pend_wr = 1'b0, pend_rd = 1'b0;
  logic [2:0]  pend_addr = 3'd0;
  logic [31:0] pend_data = 32'd0;
  int          ncyc = 0, last_rd = -10;
  int          viol_both = 0, viol_space = 0, viol_drain = 0, viol_hold = 0;
  bit          prev_mv = 1'b0, prev_mr = 1'b0;
  logic [31:0] prev_md = 32'd0;

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic int exp_bus_fn(input bit dir, input int words);
    if (words == 0) return 0;
    return dir ? words + 2 : words + 3;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Bus monitor: samples strobes mid-cycle, logs accesses, checks protocol rules.
  always begin
    @(negedge clk);
    #1;
    pend_wr   <= avm_write;
    pend_rd   <= avm_read;
    pend_addr <= avm_address;
    pend_data <= avm_writedata;
    if (avm_write || avm_read) ev_q.push_back('{ncyc, avm_write, avm_address, avm_writedata});
    if (avm_write && avm_read) viol_both <= viol_both + 1;
    if (avm_read) begin
      if (ncyc - last_rd < 2) viol_space <= viol_space + 1;
      last_rd <= ncyc;
    end
    if (avm_read && m_valid && !m_ready) viol_drain <= viol_drain + 1;
    if (prev_mv && !prev_mr && !(m_valid && m_data === prev_md)) viol_hold <= viol_hold + 1;
    prev_mv <= m_valid;
    prev_mr <= m_ready;
    prev_md <= m_data;
    ncyc    <= ncyc + 1;
  end

  // dpRam slave model: host address, write-enable, auto-incrementing data window.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed(i);
      ram_init <= 1'b1;
    end else if (pend_wr) begin
      case (pend_addr)
        3'd0: begin
          if (hwe) ram[haddr] <= pend_data;
          haddr <= haddr + 11'd1;
        end
        3'd1: haddr <= pend_data[10:0];
        3'd2: hwe <= pend_data[0];
        default: ;
      endcase
    end else if (pend_rd && pend_addr == 3'd0) begin
      avm_readdata <= ram[haddr];
      haddr        <= haddr + 11'd1;
    end
  end

  task automatic check_idle_outputs(input string name);
    check(name, 64'({cmd_ready, busy, s_ready, avm_write, avm_read, m_valid, done,
                     avm_address, avm_writedata, m_data}),
          64'({1'b1, 6'b0, 3'd0, 32'd0, 32'd0}));
  endtask

  // pol 0: always valid/ready; 1: random; 2: write gap of 5 after word 1,
  // or m_ready low for 10 cycles once the first read word is presented.
  task automatic do_cmd(input bit dir, input logic [10:0] base, input logic [11:0] len,
                        input int pol, input bit inject, input int exp_words,
                        input int exp_bus, input int abort_at);
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    int          s, nacc, cnt, hold, bad, n;
    bit          seen_done, aborted;
    ev_t         e, e2;
    logic [10:0] a;
    s = ev_q.size(); nacc = 0; cnt = 0; hold = 0; seen_done = 0; aborted = 0;
    for (int i = 0; i < exp_words; i++) wq.push_back($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_base = base; cmd_len = len;
    #1;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    while (!seen_done && !aborted && cnt < 6000) begin
      if (abort_at > 0 && nacc == abort_at) begin
        resetn = 1'b0;
        #1;
        check_idle_outputs("abort_reset_outputs");
        aborted = 1'b1;
      end else begin
        if (inject && cnt == 2) begin
          cmd_valid = 1'b1; cmd_dir = ~dir; cmd_base = ~base; cmd_len = 12'd5;
        end else begin
          cmd_valid = 1'b0;
        end
        if (!dir) begin
          if (pol == 2 && nacc == 2 && hold < 5) begin
            s_valid = 1'b0; hold++;
          end else begin
            s_valid = (pol == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          s_data = (nacc < wq.size()) ? wq[nacc] : $urandom;
        end else begin
          if (pol == 2 && m_valid && rq.size() == 0 && hold < 10) begin
            m_ready = 1'b0; hold++;
          end else begin
            m_ready = (pol == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          end
        end
        #1;
        if (cnt == 0) check("busy_after_accept", 64'(busy), 64'(len != 12'd0));
        if (done) begin
          seen_done = 1'b1;
          check("done_idle_flags", 64'({busy, cmd_ready}), 64'(2'b01));
        end else begin
          if (!dir && s_valid && s_ready) nacc++;
          if (dir && m_valid && m_ready) rq.push_back(m_data);
          @(negedge clk);
          cnt++;
        end
      end
    end
    s_valid = 1'b0; m_ready = 1'b0; cmd_valid = 1'b0;

    if (aborted) begin
      for (int i = 0; i < nacc; i++) begin
        a = base + 11'(i);
        ref_mem[a] = wq[i];
      end
      @(negedge clk);
      resetn = 1'b1;
      $display("txn abort dir=%0d base=%03h len=%0d words_before_reset=%0d", dir, base, len, nacc);
      return;
    end

    check("done_seen", 64'(seen_done), 64'd1);
    @(negedge clk);
    #1;
    check("done_single_pulse", 64'({done, cmd_ready}), 64'(2'b01));

    n = ev_q.size() - s;
    check("bus_count", 64'(n), 64'(exp_bus));
    if (!dir) begin
      check("words_accepted", 64'(nacc), 64'(exp_words));
      for (int i = 0; i < nacc; i++) begin
        a = base + 11'(i);
        ref_mem[a] = wq[i];
      end
    end else begin
      check("words_delivered", 64'(rq.size()), 64'(exp_words));
      bad = 0;
      for (int i = 0; i < rq.size() && i < exp_words; i++) begin
        a = base + 11'(i);
        if (rq[i] !== ref_mem[a]) bad++;
      end
      check("read_words_bad", 64'(bad), 64'd0);
    end

    if (exp_words > 0 && n == exp_bus) begin
      if (!dir) begin
        e = ev_q[s];
        check("w_reg1_base", 64'({e.wr, e.addr, e.data}), 64'({1'b1, 3'd1, 21'd0, base}));
        e = ev_q[s + 1];
        check("w_reg2_on", 64'({e.wr, e.addr, e.data}), 64'({1'b1, 3'd2, 32'd1}));
        bad = 0;
        for (int i = 0; i < exp_words; i++) begin
          e = ev_q[s + 2 + i];
          if ({e.wr, e.addr, e.data} !== {1'b1, 3'd0, wq[i]}) bad++;
        end
        check("w_data_events_bad", 64'(bad), 64'd0);
        e  = ev_q[s + exp_words + 2];
        e2 = ev_q[s + exp_words + 1];
        check("w_reg2_off", 64'({e.wr, e.addr, e.data}), 64'({1'b1, 3'd2, 32'd0}));
        check("w_off_gap", 64'(e.cyc - e2.cyc), 64'd1);
        if (pol == 0) check("w_back_to_back", 64'(e.cyc - ev_q[s + 2].cyc), 64'(exp_words));
      end else begin
        e = ev_q[s];
        check("r_reg2_off", 64'({e.wr, e.addr, e.data}), 64'({1'b1, 3'd2, 32'd0}));
        e = ev_q[s + 1];
        check("r_reg1_base", 64'({e.wr, e.addr, e.data}), 64'({1'b1, 3'd1, 21'd0, base}));
        bad = 0;
        for (int i = 0; i < exp_words; i++) begin
          e = ev_q[s + 2 + i];
          if (e.wr || e.addr != 3'd0) bad++;
        end
        check("r_read_events_bad", 64'(bad), 64'd0);
      end
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_contents_bad", 64'(bad), 64'd0);
    $display("txn dir=%0d base=%03h len=%0d pol=%0d words=%0d bus=%0d", dir, base, len, pol,
             dir ? rq.size() : nacc, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    bit   rdir;
    int   rlen;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);

    //          dir   base     len       pol inj   words bus
    tbl[0]  = '{1'b0, 11'h010, 12'd4,    0, 1'b0, 4,    7};
    tbl[1]  = '{1'b0, 11'h7FE, 12'd4,    0, 1'b0, 4,    7};
    tbl[2]  = '{1'b1, 11'h7FE, 12'd4,    0, 1'b0, 4,    6};
    tbl[3]  = '{1'b0, 11'h020, 12'd3,    2, 1'b0, 3,    6};
    tbl[4]  = '{1'b1, 11'h020, 12'd3,    2, 1'b0, 3,    5};
    tbl[5]  = '{1'b0, 11'h100, 12'd0,    0, 1'b0, 0,    0};
    tbl[6]  = '{1'b0, 11'h200, 12'd9,    1, 1'b1, 9,    12};
    tbl[7]  = '{1'b1, 11'h1FC, 12'd16,   1, 1'b1, 16,   18};
    tbl[8]  = '{1'b0, 11'h000, 12'd3000, 0, 1'b0, 2048, 2051};
    tbl[9]  = '{1'b1, 11'h005, 12'd4095, 0, 1'b0, 2048, 2050};
    tbl[10] = '{1'b1, 11'h333, 12'd0,    0, 1'b0, 0,    0};

    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset_outputs");
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 11; k++)
      do_cmd(tbl[k].dir, tbl[k].base, tbl[k].len, tbl[k].pol, tbl[k].inject,
             tbl[k].exp_words, tbl[k].exp_bus, 0);

    // Reset in the middle of the data phase, then a clean short write.
    do_cmd(1'b0, 11'h300, 12'd8, 0, 1'b0, 8, 11, 3);
    do_cmd(1'b0, 11'h300, 12'd2, 0, 1'b0, 2, 5, 0);
    do_cmd(1'b1, 11'h2FF, 12'd6, 1, 1'b0, 6, 8, 0);

    for (int r = 0; r < 20; r++) begin
      rdir = 1'($urandom_range(0, 1));
      rlen = $urandom_range(0, 24);
      do_cmd(rdir, 11'($urandom), 12'(rlen), 1, 1'b0, rlen, exp_bus_fn(rdir, rlen), 0);
    end

    repeat (2) @(negedge clk);
    check("viol_read_write_same_cycle", 64'(viol_both), 64'd0);
    check("viol_read_spacing", 64'(viol_space), 64'd0);
    check("viol_read_while_full", 64'(viol_drain), 64'd0);
    check("viol_m_hold", 64'(viol_hold), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
